// File: rtl/fdd_track_writeback.sv
// fdd_track_writeback
//   Writes dirty sectors of the floppy track buffer back to the SD image.
//   Each byte the disk controller stores into the track buffer marks its
//   sector dirty. A flush pulse, about a second without buffer writes, or a
//   head move away from the dirty track starts a flush. The flush writes
//   every dirty sector, lowest index first, through the hps_io
//   sd_wr/sd_ack/sd_lba handshake. The CPU is stalled during a flush, except
//   for a timeout flush while the head stays on the dirty track.
//
// Ports
//   clk_sys        system clock
//   reset          synchronous, active-high reset
//   track[5:0]     current head track
//   fd_write_disk  track-buffer write strobe, one cycle per byte
//   fd_track_addr  track-buffer address: [12:9] sector, [8:0] byte
//   img_mounted    one-cycle pulse when a new image is mounted
//   img_readonly   image is read-only, sampled on img_mounted
//   flush          one-cycle request for an immediate flush
//   sd_ack         hps_io acknowledge for drive 0
//   sd_lba[31:0]   LBA of the sector being written (SECTORS*track + sector)
//   sd_wr          write request to hps_io
//   buf_sec[3:0]   sector whose bytes hps_io reads ({buf_sec, sd_buff_addr})
//   cpu_wait       CPU stall
//   dirty          at least one sector is waiting to be written
//   state_dbg[2:0] current controller state, for observation only
//
// Handshake: sd_wr rises with sd_lba/buf_sec already valid and stays high
// until a rising edge of sd_ack. sd_wr then drops, and the sector counts as
// written on the following falling edge of sd_ack. sd_lba and buf_sec do
// not change from the rise of sd_wr until that falling edge. A started
// handshake is always completed, even when a new image is mounted.
module fdd_track_writeback #(
  parameter int SECTORS     = 13,
  parameter int IDLE_CYCLES = 14000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        fd_write_disk,
  input  logic [13:0] fd_track_addr,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        flush,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_wr,
  output logic [3:0]  buf_sec,
  output logic        cpu_wait,
  output logic        dirty,
  output logic [2:0]  state_dbg
);

  localparam logic [31:0] SECTORS_W = SECTORS;
  localparam logic [31:0] IDLE_W    = IDLE_CYCLES;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_REQ  = 3'd2,
    S_XFER = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state;
  logic [SECTORS-1:0] mask;
  logic [5:0]         dirty_track;
  logic               protect;
  logic [31:0]        idle_cnt;
  logic               old_ack;
  logic               abort;   // image changed during a handshake

  logic [3:0]         sec;
  logic               mark;
  logic [SECTORS-1:0] set_vec;
  logic [SECTORS-1:0] clr_vec;
  logic [SECTORS-1:0] mask_nxt;
  logic [3:0]         low_idx;
  logic               ack_rise;
  logic               ack_fall;
  logic               mask_any;
  logic               track_moved;
  logic               timeout;
  logic               trigger;
  logic               xfer_end;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{fd_track_addr[13], fd_track_addr[8:0]};
  assign dirty            = |mask;
  assign state_dbg        = state;

  always_comb begin
    sec      = fd_track_addr[12:9];
    mark     = fd_write_disk && !protect && ({28'd0, sec} < SECTORS_W);
    set_vec  = '0;
    if (mark) set_vec[sec] = 1'b1;

    ack_rise = sd_ack && !old_ack;
    ack_fall = !sd_ack && old_ack;

    // Lowest dirty sector wins, so scan from the top down.
    low_idx = '0;
    for (int i = SECTORS - 1; i >= 0; i--) begin
      if (mask[i]) low_idx = 4'(i);
    end

    mask_any    = |mask;
    track_moved = (track != dirty_track);
    timeout     = (idle_cnt == IDLE_W);
    trigger     = (state == S_IDLE) && !img_mounted && mask_any &&
                  (flush || timeout || track_moved);
    xfer_end    = (state == S_XFER) && ack_fall;

    clr_vec = '0;
    if (img_mounted && (state == S_IDLE || state == S_SCAN)) begin
      clr_vec = '1;
    end else if (xfer_end) begin
      if (abort || img_mounted) clr_vec = '1;
      else                      clr_vec[buf_sec] = 1'b1;
    end

    // A write landing on the sector just finished keeps it dirty.
    mask_nxt = (mask & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      mask        <= '0;
      dirty_track <= '0;
      protect     <= 1'b0;
      idle_cnt    <= '0;
      old_ack     <= 1'b0;
      abort       <= 1'b0;
      sd_wr       <= 1'b0;
      sd_lba      <= '0;
      buf_sec     <= '0;
      cpu_wait    <= 1'b0;
    end else begin
      old_ack <= sd_ack;
      mask    <= mask_nxt;

      if (img_mounted) protect <= img_readonly;

      // The track is captured only by the first write into an empty mask.
      if (mark && !mask_any) dirty_track <= track;

      if (mark || state == S_DONE ||
          (img_mounted && (state == S_IDLE || state == S_SCAN))) begin
        idle_cnt <= '0;
      end else if (state == S_IDLE && mask_any && !timeout) begin
        idle_cnt <= idle_cnt + 32'd1;
      end

      // A quiet timeout flush must still stall the CPU once the head moves.
      if ((state == S_SCAN || state == S_REQ || state == S_XFER) && track_moved) begin
        cpu_wait <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          abort <= 1'b0;
          if (img_mounted) begin
            cpu_wait <= 1'b0;
          end else if (trigger) begin
            state    <= S_SCAN;
            cpu_wait <= flush || track_moved;
          end
        end
        S_SCAN: begin
          if (img_mounted) begin
            state    <= S_IDLE;
            cpu_wait <= 1'b0;
          end else if (!mask_any) begin
            state <= S_DONE;
          end else begin
            buf_sec <= low_idx;
            sd_lba  <= SECTORS_W * {26'd0, dirty_track} + {28'd0, low_idx};
            sd_wr   <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (img_mounted) abort <= 1'b1;
          if (ack_rise) begin
            sd_wr <= 1'b0;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (img_mounted) abort <= 1'b1;
          if (ack_fall) begin
            state <= (abort || img_mounted || mask_nxt == '0) ? S_DONE : S_SCAN;
          end
        end
        S_DONE: begin
          cpu_wait <= 1'b0;
          abort    <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdd_track_writeback.sv
module tb_fdd_track_writeback;

  localparam int SECTORS     = 13;
  localparam int IDLE_CYCLES = 100;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  track = '0;
  logic        fd_write_disk = 1'b0;
  logic [13:0] fd_track_addr = '0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic        flush = 1'b0;
  logic        sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_wr;
  logic [3:0]  buf_sec;
  logic        cpu_wait;
  logic        dirty;
  logic [2:0]  state_dbg;

  always #5 clk_sys = ~clk_sys;

  fdd_track_writeback #(.SECTORS(SECTORS), .IDLE_CYCLES(IDLE_CYCLES)) dut (
    .clk_sys(clk_sys), .reset(reset), .track(track),
    .fd_write_disk(fd_write_disk), .fd_track_addr(fd_track_addr),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .flush(flush),
    .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_wr(sd_wr), .buf_sec(buf_sec),
    .cpu_wait(cpu_wait), .dirty(dirty), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [35:0] exp_q[$];     // {sector, lba} of each expected write request
  logic [31:0] seen_q[$];    // lba of each write request observed
  logic        wait_exp = 1'b1;
  bit          chk_en = 1'b0;
  logic        prev_wr = 1'b0;
  logic [35:0] cur_req = '0;
  bit          have_req = 1'b0;

  // Behavioural model: a set of dirty sectors plus the track they belong to.
  bit mdl_mask[SECTORS];
  int mdl_track = 0;
  bit mdl_protect = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit mdl_empty();
    for (int i = 0; i < SECTORS; i++) if (mdl_mask[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_write(input int s);
    if (!mdl_protect && s < SECTORS) begin
      if (mdl_empty()) mdl_track = int'(track);
      mdl_mask[s] = 1'b1;
    end
  endtask

  // A flush writes every dirty sector in ascending order.
  task automatic model_flush(output int n);
    n = 0;
    for (int i = 0; i < SECTORS; i++) begin
      if (mdl_mask[i]) begin
        exp_q.push_back({4'(i), 32'(SECTORS * mdl_track + i)});
        mdl_mask[i] = 1'b0;
        n++;
      end
    end
  endtask

  // A new image drops every sector whose request has not started yet.
  task automatic model_mount(input bit ro);
    mdl_protect = ro;
    for (int i = 0; i < SECTORS; i++) mdl_mask[i] = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_reset();
    mdl_protect = 1'b0;
    for (int i = 0; i < SECTORS; i++) mdl_mask[i] = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_addr(input logic [13:0] a);
    fd_track_addr = a;
    fd_write_disk = 1'b1;
    model_write(int'(a[12:9]));
    @(negedge clk_sys);
    fd_write_disk = 1'b0;
  endtask

  task automatic write_sec(input int s);
    write_addr({1'b0, 4'(s), 9'($urandom_range(0, 511))});
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk_sys);
    flush = 1'b0;
  endtask

  task automatic wait_wr(input string tag);
    int k = 0;
    while (!sd_wr && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    chk({tag, "_req_seen"}, 32'(sd_wr), 32'd1);
  endtask

  // Acts as hps_io for one sector; optionally writes a byte on the ack fall.
  task automatic serve_one(input bit inject, input int inj_sec);
    int k = 0;
    while (!sd_wr && k < 100) begin
      @(negedge clk_sys);
      k++;
    end
    chk("serve_req_seen", 32'(sd_wr), 32'd1);
    if (!sd_wr) return;
    repeat ($urandom_range(0, 3)) @(negedge clk_sys);
    sd_ack = 1'b1;
    k = 0;
    while (sd_wr && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    chk("serve_wr_drop", 32'(sd_wr), 32'd0);
    repeat ($urandom_range(0, 3)) @(negedge clk_sys);
    sd_ack = 1'b0;
    if (inject) begin
      fd_track_addr = {1'b0, 4'(inj_sec), 9'h0AA};
      fd_write_disk = 1'b1;
      model_write(inj_sec);
    end
    @(negedge clk_sys);
    fd_write_disk = 1'b0;
  endtask

  task automatic finish_flush(input string tag);
    repeat (3) @(negedge clk_sys);
    chk({tag, "_dirty"}, 32'(dirty), 32'd0);
    chk({tag, "_cpu_wait"}, 32'(cpu_wait), 32'd0);
    chk({tag, "_sd_wr"}, 32'(sd_wr), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk_sys);
      if (chk_en) begin
        if (sd_wr && !prev_wr) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_sd_wr", 32'(sd_wr), 32'd0);
          end else begin
            cur_req  = exp_q.pop_front();
            have_req = 1'b1;
            chk("sd_lba", sd_lba, cur_req[31:0]);
            chk("buf_sec", 32'(buf_sec), 32'(cur_req[35:32]));
            seen_q.push_back(sd_lba);
          end
        end else if ((sd_wr || sd_ack) && have_req) begin
          chk("lba_stable", sd_lba, cur_req[31:0]);
          chk("buf_sec_stable", 32'(buf_sec), 32'(cur_req[35:32]));
        end
        if (sd_wr) chk("cpu_wait_during_req", 32'(cpu_wait), 32'(wait_exp));
      end
      prev_wr = sd_wr;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int k;
    int t;
    int lits[3];
    lits = '{39, 46, 51};

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_sd_wr", 32'(sd_wr), 32'd0);
    chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    chk("rst_sd_lba", sd_lba, 32'd0);
    chk("rst_buf_sec", 32'(buf_sec), 32'd0);
    chk("rst_dirty", 32'(dirty), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk_sys);

    // Single sector, flush pulse, exact latency
    track = 6'd5;
    @(negedge clk_sys);
    write_addr(14'h0405);
    chk("t1_dirty_set", 32'(dirty), 32'd1);
    wait_exp = 1'b1;
    model_flush(n);
    pulse_flush();
    chk("t1_wait_early", 32'(cpu_wait), 32'd1);
    chk("t1_wr_early", 32'(sd_wr), 32'd0);
    @(negedge clk_sys);
    chk("t1_wr", 32'(sd_wr), 32'd1);
    chk("t1_lba", sd_lba, 32'd67);
    chk("t1_sec", 32'(buf_sec), 32'd2);
    serve_one(1'b0, 0);
    finish_flush("t1");

    // Three sectors written out of order on track 3
    track = 6'd3;
    @(negedge clk_sys);
    seen_q.delete();
    write_sec(12);
    write_sec(0);
    write_sec(7);
    model_flush(n);
    pulse_flush();
    repeat (n) serve_one(1'b0, 0);
    finish_flush("t2");
    chk("t2_count", 32'(seen_q.size()), 32'd3);
    for (int i = 0; i < seen_q.size() && i < 3; i++) chk("t2_lba_lit", seen_q[i], 32'(lits[i]));

    // Head moves away from the dirty track
    track = 6'd10;
    @(negedge clk_sys);
    seen_q.delete();
    write_sec(4);
    repeat (3) @(negedge clk_sys);
    model_flush(n);
    track = 6'd11;
    serve_one(1'b0, 0);
    finish_flush("t3");
    chk("t3_count", 32'(seen_q.size()), 32'd1);
    if (seen_q.size() > 0) chk("t3_lba_lit", seen_q[0], 32'd134);

    // Idle timeout: no stall, request two cycles after the counter saturates
    track = 6'($urandom_range(0, 63));
    @(negedge clk_sys);
    wait_exp = 1'b0;
    write_sec(1);
    model_flush(n);
    k = 0;
    while (!sd_wr && k < 300) begin
      @(negedge clk_sys);
      k++;
    end
    chk("t4_timeout_cycles", 32'(k), 32'(IDLE_CYCLES + 2));
    chk("t4_lba", sd_lba, 32'(13 * int'(track) + 1));
    serve_one(1'b0, 0);
    finish_flush("t4");
    wait_exp = 1'b1;

    // Read-only image, then out-of-range sectors on a writable image
    img_readonly = 1'b1;
    img_mounted = 1'b1;
    model_mount(1'b1);
    @(negedge clk_sys);
    img_mounted = 1'b0;
    img_readonly = 1'b0;
    write_sec(3);
    pulse_flush();
    repeat (10) @(negedge clk_sys);
    chk("t5_ro_dirty", 32'(dirty), 32'd0);
    chk("t5_ro_sd_wr", 32'(sd_wr), 32'd0);
    img_mounted = 1'b1;
    model_mount(1'b0);
    @(negedge clk_sys);
    img_mounted = 1'b0;
    write_addr(14'h1A00);
    write_addr(14'h1E10);
    repeat (3) @(negedge clk_sys);
    chk("t5_sec13_dirty", 32'(dirty), 32'd0);
    pulse_flush();
    repeat (4) @(negedge clk_sys);
    chk("t5_sec13_wait", 32'(cpu_wait), 32'd0);

    // Write on the same cycle the sector's transfer completes
    track = 6'($urandom_range(0, 63));
    @(negedge clk_sys);
    seen_q.delete();
    write_sec(5);
    model_flush(n);
    pulse_flush();
    serve_one(1'b1, 5);
    model_flush(n);
    serve_one(1'b0, 0);
    finish_flush("t6");
    chk("t6_count", 32'(seen_q.size()), 32'd2);
    for (int i = 0; i < seen_q.size(); i++) chk("t6_lba", seen_q[i], 32'(13 * int'(track) + 5));

    // Mount during REQ: current handshake completes, rest dropped
    track = 6'($urandom_range(0, 63));
    @(negedge clk_sys);
    write_sec(2);
    write_sec(6);
    model_flush(n);
    pulse_flush();
    wait_wr("t7");
    img_mounted = 1'b1;
    model_mount(1'b0);
    @(negedge clk_sys);
    img_mounted = 1'b0;
    chk("t7_wr_held", 32'(sd_wr), 32'd1);
    serve_one(1'b0, 0);
    repeat (20) @(negedge clk_sys);
    chk("t7_dirty", 32'(dirty), 32'd0);
    chk("t7_cpu_wait", 32'(cpu_wait), 32'd0);
    chk("t7_sd_wr", 32'(sd_wr), 32'd0);

    // Reset during REQ
    track = 6'($urandom_range(0, 63));
    @(negedge clk_sys);
    write_sec(9);
    model_flush(n);
    pulse_flush();
    wait_wr("t8");
    reset = 1'b1;
    model_reset();
    @(negedge clk_sys);
    chk("t8_sd_wr", 32'(sd_wr), 32'd0);
    chk("t8_cpu_wait", 32'(cpu_wait), 32'd0);
    chk("t8_dirty", 32'(dirty), 32'd0);
    chk("t8_sd_lba", sd_lba, 32'd0);
    chk("t8_buf_sec", 32'(buf_sec), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Largest LBA
    track = 6'd63;
    @(negedge clk_sys);
    seen_q.delete();
    write_sec(12);
    model_flush(n);
    pulse_flush();
    serve_one(1'b0, 0);
    finish_flush("t9");
    if (seen_q.size() > 0) chk("t9_lba_lit", seen_q[0], 32'd831);
    else chk("t9_count", 32'(seen_q.size()), 32'd1);

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      track = 6'($urandom_range(0, 63));
      @(negedge clk_sys);
      repeat ($urandom_range(1, 6)) begin
        write_sec($urandom_range(0, 15));
        repeat ($urandom_range(0, 3)) @(negedge clk_sys);
      end
      model_flush(n);
      if ($urandom_range(0, 1) == 1) begin
        pulse_flush();
      end else begin
        t = (int'(track) + 1 + $urandom_range(0, 61)) % 64;
        track = 6'(t);
      end
      repeat (n) serve_one(1'b0, 0);
      finish_flush("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fdd_track_writeback.md
Name: fdd_track_writeback

Overview:
- Write-back controller for the floppy track buffer (13 x 512-byte sectors per track).
- The disk controller writes nibbles into the track buffer. This block records which sectors are dirty and writes them back to the SD image through the hps_io sd_wr/sd_ack/sd_lba handshake.
- It is the write-direction counterpart of the track loader. It stalls the CPU while a flush is in progress.

Parameters:
- SECTORS, 13, sectors per track; the image LBA is SECTORS*track + sector.
- IDLE_CYCLES, 14000000, cycles with no track-buffer write (about 1 s at 14 MHz) before an automatic flush.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- track  in  6  current head track from the disk controller.
- fd_write_disk  in  1  track-buffer write strobe, one cycle per byte.
- fd_track_addr  in  14  track-buffer address; bits [12:9] are the sector, [8:0] the byte.
- img_mounted  in  1  single-cycle pulse when a new image is mounted.
- img_readonly  in  1  image is read-only; valid on the img_mounted pulse.
- flush  in  1  single-cycle pulse requesting an immediate flush.
- sd_ack  in  1  hps_io acknowledge for drive 0.
- sd_lba  out  32  LBA of the sector being written.
- sd_wr  out  1  write request to hps_io.
- buf_sec  out  4  sector index; the top level forms the buffer read address as {buf_sec, sd_buff_addr}.
- cpu_wait  out  1  CPU stall.
- dirty  out  1  OR of the dirty mask.

Behaviour:
- Reset values: sd_wr=0, cpu_wait=0, sd_lba=0, buf_sec=0, dirty=0. Dirty mask cleared, idle counter 0, protect flag 0, state IDLE.
- Protect flag: latched from img_readonly on img_mounted.
- Dirty marking: on fd_write_disk with fd_track_addr[12:9] < SECTORS and protect=0:
  - set mask[fd_track_addr[12:9]];
  - if the mask was empty, latch dirty_track <= track;
  - reset the idle counter.
- Sector indices 13-15 are ignored.
- Idle counter: counts while the mask is non-zero and the state is IDLE. It saturates at IDLE_CYCLES, which generates a trigger.
- Triggers, evaluated in IDLE only: flush pulse, idle timeout, or (mask != 0 and track != dirty_track). A trigger with an empty mask is a no-op.
- State machine:
  - IDLE: on a trigger with mask != 0, go to SCAN and set cpu_wait=1. Exception: the idle-timeout trigger leaves cpu_wait=0, but cpu_wait is forced to 1 if a track change is seen before DONE.
  - SCAN: sel <= lowest set mask index. Go to REQ with sd_lba <= SECTORS*dirty_track + sel, buf_sec <= sel, sd_wr <= 1. sd_wr is therefore high 2 cycles after the trigger cycle.
  - REQ: hold sd_wr=1 until a sd_ack rising edge (registered old_ack), then sd_wr <= 0 and go to XFER.
  - XFER: wait for the sd_ack falling edge, then clear mask[sel]. Go to SCAN if other bits remain, else go to DONE.
  - DONE: cpu_wait <= 0, idle counter cleared, go to IDLE. Total cpu_wait latency = trigger + per-sector handshakes + 1 cycle.
- Set and clear on the same cycle, same bit: the set wins and the sector is written again later.
- Writes during REQ/XFER are still marked. dirty_track is not relatched unless the mask is empty.
- img_mounted:
  - in IDLE/SCAN: clear the mask and go to IDLE; cpu_wait <= 0.
  - in REQ before ack: keep sd_wr until ack, then finish the handshake.
  - in REQ/XFER: after the ack fall, clear the whole mask and go to DONE. Never abandon a started handshake.
- LBA arithmetic: SECTORS*dirty_track is computed in 32 bits with no overflow (max 13*63+12=831).
- buf_sec and sd_lba stay stable from REQ entry until the XFER exit.
- reset mid-transfer: outputs return to reset values immediately; mask lost. This is acceptable: the host times out the ack.

Test Plan:
- Write 1 byte at fd_track_addr=0x0405 (sector 2) on track 5, then a flush pulse -> sd_wr high 2 cycles later with sd_lba=67, buf_sec=2. Ack 1->0 clears the mask, then dirty=0 and cpu_wait=0.
- Writes to sectors 0, 7, 12 on track 3, then flush -> three handshakes in order with lba 39, 46, 51; cpu_wait held high throughout.
- Write sector 4 on track 10, then change track to 11 -> auto flush with lba 134 (old track) and cpu_wait=1 until DONE.
- Write sector 1 then no activity for IDLE_CYCLES (set to 100 in the bench) -> flush starts at cycle 100 with cpu_wait=0; lba = 13*track+1.
- Mount with img_readonly=1, then write sector 3 and flush -> dirty stays 0, sd_wr never asserts. Write to address 0x1A00 (sector 13) with a writable image -> ignored.
- Write sector 5 while sector 5 is in XFER (set/clear on the same cycle) -> sector 5 is written twice. img_mounted during REQ -> the current handshake completes, the mask is cleared, no further sd_wr. reset during REQ -> sd_wr=0 next cycle.
